// File: rtl/nv_timeout_supervisor_pkg.sv
// nv_timeout_supervisor_pkg
//   Shared types for the NV-op timeout supervisor: the FSM state encoding
//   (3 bits, IDLE..ERROR) and the decoded Moore outputs that depend on the
//   registered state alone.
package nv_timeout_supervisor_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StIssue   = 3'd1,
        StWait    = 3'd2,
        StAbort   = 3'd3,
        StBackoff = 3'd4,
        StError   = 3'd5
    } sup_state_e;

    typedef struct packed {
        logic timer_reset;
        logic op_issue;
        logic op_abort;
        logic busy;
    } sup_decode_t;

    // Decoded outputs as a pure function of the state register.
    // timer_reset stays high everywhere except WAIT, so a sticky timeout left
    // over from a previous attempt is always cleared before the next WAIT.
    function automatic sup_decode_t decode_state(sup_state_e s);
        sup_decode_t d;
        d.timer_reset = (s != StWait);
        d.op_issue    = (s == StIssue);
        d.op_abort    = (s == StAbort);
        d.busy        = (s != StIdle);
        return d;
    endfunction

endpackage

// File: rtl/nv_timeout_supervisor.sv
// nv_timeout_supervisor
//   Consumer end of the NV-op timeout path. Supervises one NV operation at a
//   time: issue, wait for completion, abort on timeout, back off, retry up to
//   MAX_RETRY times, then report an error until acknowledged.
//   The external one-shot timeout timer is owned by the parent; this block only
//   drives its reset and watches its sticky interrupt.
// Ports
//   clk                  clock
//   reset                synchronous, active-high
//   op_start_i           1-cycle start request, sampled only in IDLE
//   op_done_i            1-cycle completion pulse, honoured only in WAIT
//   timeout_interrupt_i  sticky timeout from the external timer
//   err_ack_i            leaves ERROR, honoured only in ERROR
//   timer_reset_o        external timer reset, low only in WAIT
//   op_issue_o           1-cycle (re)issue pulse (ISSUE state)
//   op_abort_o           1-cycle abort pulse (ABORT state)
//   busy_o               high in every state except IDLE
//   done_ok_o            registered 1-cycle pulse, first IDLE cycle after success
//   done_err_o           registered 1-cycle pulse, first ERROR cycle
//   retry_count_o        retries consumed for the current/last op
module nv_timeout_supervisor
    import nv_timeout_supervisor_pkg::*;
#(
    parameter int unsigned MAX_RETRY      = 2,
    parameter int unsigned RETRY_W        = 2,
    parameter int unsigned BACKOFF_CYCLES = 16,
    parameter int unsigned BACKOFF_W      = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_start_i,
    input  logic               op_done_i,
    input  logic               timeout_interrupt_i,
    input  logic               err_ack_i,
    output logic               timer_reset_o,
    output logic               op_issue_o,
    output logic               op_abort_o,
    output logic               busy_o,
    output logic               done_ok_o,
    output logic               done_err_o,
    output logic [RETRY_W-1:0] retry_count_o
);

    localparam logic [RETRY_W-1:0]   RetryMax    = RETRY_W'(MAX_RETRY);
    // Counter runs BACKOFF_CYCLES-1 down to 0, giving BACKOFF_CYCLES cycles.
    localparam logic [BACKOFF_W-1:0] BackoffLoad = BACKOFF_W'(BACKOFF_CYCLES - 1);

    sup_state_e           state_q;
    logic [RETRY_W-1:0]   retry_q;
    logic [BACKOFF_W-1:0] backoff_q;
    logic                 done_ok_q;
    logic                 done_err_q;
    sup_decode_t          dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            retry_q    <= '0;
            backoff_q  <= '0;
            done_ok_q  <= 1'b0;
            done_err_q <= 1'b0;
        end else begin
            // Completion pulses last exactly one cycle.
            done_ok_q  <= 1'b0;
            done_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (op_start_i) begin
                        state_q <= StIssue;
                        retry_q <= '0;
                    end
                end
                StIssue: begin
                    state_q <= StWait;
                end
                StWait: begin
                    // Completion beats a coincident timeout.
                    if (op_done_i) begin
                        state_q   <= StIdle;
                        done_ok_q <= 1'b1;
                    end else if (timeout_interrupt_i) begin
                        state_q <= StAbort;
                    end
                end
                StAbort: begin
                    // >= rather than == keeps the counter saturated even if
                    // it were ever observed past the limit.
                    if (retry_q >= RetryMax) begin
                        state_q    <= StError;
                        done_err_q <= 1'b1;
                    end else begin
                        state_q   <= StBackoff;
                        retry_q   <= retry_q + 1'b1;
                        backoff_q <= BackoffLoad;
                    end
                end
                StBackoff: begin
                    if (backoff_q == '0) begin
                        state_q <= StIssue;
                    end else begin
                        backoff_q <= backoff_q - 1'b1;
                    end
                end
                StError: begin
                    if (err_ack_i) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign dec           = decode_state(state_q);
    assign timer_reset_o = dec.timer_reset;
    assign op_issue_o    = dec.op_issue;
    assign op_abort_o    = dec.op_abort;
    assign busy_o        = dec.busy;
    assign done_ok_o     = done_ok_q;
    assign done_err_o    = done_err_q;
    assign retry_count_o = retry_q;

endmodule

// File: tb/tb_nv_timeout_supervisor.sv
// tb_nv_timeout_supervisor
//   Directed bench for nv_timeout_supervisor with MAX_RETRY=2, BACKOFF_CYCLES=4.
//   A small model of the external one-shot timer raises a sticky interrupt
//   after TIMEOUT cycles of timer_reset low; force_to lets a test inject a
//   timeout on a chosen cycle.
module tb_nv_timeout_supervisor;

    localparam int TIMEOUT = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       op_start = 1'b0;
    logic       op_done = 1'b0;
    logic       err_ack = 1'b0;
    logic       force_to = 1'b0;
    logic       tint = 1'b0;
    int         tcnt = 0;
    logic       timeout_w;
    logic       timer_reset;
    logic       op_issue;
    logic       op_abort;
    logic       busy;
    logic       done_ok;
    logic       done_err;
    logic [1:0] retry_count;

    int n_cmp = 0;
    int n_err = 0;

    // Pulse counters, sampled at each edge (i.e. the value held during the cycle).
    int cnt_issue = 0;
    int cnt_abort = 0;
    int cnt_ok    = 0;
    int cnt_err   = 0;

    always #5 clk = ~clk;

    assign timeout_w = tint | force_to;

    nv_timeout_supervisor #(
        .MAX_RETRY      (2),
        .RETRY_W        (2),
        .BACKOFF_CYCLES (4),
        .BACKOFF_W      (3)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .op_start_i          (op_start),
        .op_done_i           (op_done),
        .timeout_interrupt_i (timeout_w),
        .err_ack_i           (err_ack),
        .timer_reset_o       (timer_reset),
        .op_issue_o          (op_issue),
        .op_abort_o          (op_abort),
        .busy_o              (busy),
        .done_ok_o           (done_ok),
        .done_err_o          (done_err),
        .retry_count_o       (retry_count)
    );

    // One-shot timer model: sticky once fired, cleared by timer_reset.
    always @(posedge clk) begin
        if (timer_reset) begin
            tcnt <= 0;
            tint <= 1'b0;
        end else if (tcnt == TIMEOUT - 1) begin
            tint <= 1'b1;
        end else begin
            tcnt <= tcnt + 1;
        end
    end

    always @(posedge clk) begin
        if (op_issue) cnt_issue <= cnt_issue + 1;
        if (op_abort) cnt_abort <= cnt_abort + 1;
        if (done_ok)  cnt_ok    <= cnt_ok + 1;
        if (done_err) cnt_err   <= cnt_err + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in its ISSUE cycle.
    task automatic start_op();
        op_start = 1'b1;
        tick();
        op_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_cmp++; if (timer_reset !== 1'b1) begin n_err++; $display("FAIL rst_timer_reset got=%b exp=1", timer_reset); end
        n_cmp++; if ({op_issue, op_abort, busy, done_ok, done_err} !== 5'b0) begin
            n_err++; $display("FAIL rst_outputs got=%b exp=00000", {op_issue, op_abort, busy, done_ok, done_err});
        end
        n_cmp++; if (retry_count !== 2'd0) begin n_err++; $display("FAIL rst_retry got=%0d exp=0", retry_count); end
        tick();
    endtask

    task automatic test_success();
        int i0, a0, o0;
        i0 = cnt_issue; a0 = cnt_abort; o0 = cnt_ok;
        start_op();
        n_cmp++; if (op_issue !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL ok_issue got=%b%b exp=11", op_issue, busy); end
        for (int k = 0; k < 20; k++) tick();
        n_cmp++; if (timer_reset !== 1'b0) begin n_err++; $display("FAIL ok_wait_timer got=%b exp=0", timer_reset); end
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        n_cmp++; if (done_ok !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL ok_done got=%b%b exp=10", done_ok, busy); end
        n_cmp++; if (retry_count !== 2'd0) begin n_err++; $display("FAIL ok_retry got=%0d exp=0", retry_count); end
        tick();
        n_cmp++; if (done_ok !== 1'b0) begin n_err++; $display("FAIL ok_pulse_width got=%b exp=0", done_ok); end
        n_cmp++; if (cnt_issue - i0 !== 1 || cnt_abort - a0 !== 0 || cnt_ok - o0 !== 1) begin
            n_err++; $display("FAIL ok_counts got=%0d/%0d/%0d exp=1/0/1", cnt_issue - i0, cnt_abort - a0, cnt_ok - o0);
        end
    endtask

    task automatic test_exhaust();
        int i0, a0, e0, n;
        bit seen;
        i0 = cnt_issue; a0 = cnt_abort; e0 = cnt_err;
        seen = 1'b0;
        n = 0;
        start_op();
        // ISSUE(1)+WAIT(41) -> ABORT at +42, BACKOFF x4, next ISSUE at +47;
        // third ABORT at +136, ERROR with done_err at +137.
        while (n < 500 && !seen) begin
            tick();
            n++;
            if (done_err) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b1 || n !== 137) begin n_err++; $display("FAIL err_latency got=%0d exp=137", n); end
        n_cmp++; if (retry_count !== 2'd2 || busy !== 1'b1) begin
            n_err++; $display("FAIL err_state got=%0d/%b exp=2/1", retry_count, busy);
        end
        tick();
        n_cmp++; if (done_err !== 1'b0) begin n_err++; $display("FAIL err_pulse_width got=%b exp=0", done_err); end
        for (int k = 0; k < 5; k++) tick();
        n_cmp++; if (busy !== 1'b1 || retry_count !== 2'd2 || op_issue !== 1'b0) begin
            n_err++; $display("FAIL err_hold got=%b/%0d/%b exp=1/2/0", busy, retry_count, op_issue);
        end
        n_cmp++; if (cnt_issue - i0 !== 3 || cnt_abort - a0 !== 3 || cnt_err - e0 !== 1) begin
            n_err++; $display("FAIL err_counts got=%0d/%0d/%0d exp=3/3/1", cnt_issue - i0, cnt_abort - a0, cnt_err - e0);
        end
        err_ack = 1'b1;
        tick();
        err_ack = 1'b0;
        n_cmp++; if (busy !== 1'b0 || done_ok !== 1'b0 || retry_count !== 2'd2) begin
            n_err++; $display("FAIL err_ack got=%b/%b/%0d exp=0/0/2", busy, done_ok, retry_count);
        end
        tick();
    endtask

    task automatic test_retry_success();
        int i0, a0, n;
        bit seen;
        i0 = cnt_issue; a0 = cnt_abort;
        start_op();
        n_cmp++; if (retry_count !== 2'd0) begin n_err++; $display("FAIL rty_clear got=%0d exp=0", retry_count); end
        seen = 1'b0; n = 0;
        while (n < 200 && !seen) begin tick(); n++; if (op_abort) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b1 || n !== 42) begin n_err++; $display("FAIL rty_abort_at got=%0d exp=42", n); end
        seen = 1'b0; n = 0;
        while (n < 50 && !seen) begin tick(); n++; if (op_issue) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b1 || n !== 5) begin n_err++; $display("FAIL rty_spacing got=%0d exp=5", n); end
        n_cmp++; if (retry_count !== 2'd1) begin n_err++; $display("FAIL rty_count got=%0d exp=1", retry_count); end
        for (int k = 0; k < 10; k++) tick();
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        n_cmp++; if (done_ok !== 1'b1 || busy !== 1'b0 || retry_count !== 2'd1) begin
            n_err++; $display("FAIL rty_done got=%b/%b/%0d exp=1/0/1", done_ok, busy, retry_count);
        end
        tick();
        n_cmp++; if (cnt_issue - i0 !== 2 || cnt_abort - a0 !== 1) begin
            n_err++; $display("FAIL rty_counts got=%0d/%0d exp=2/1", cnt_issue - i0, cnt_abort - a0);
        end
    endtask

    task automatic test_done_vs_timeout();
        int a0;
        a0 = cnt_abort;
        start_op();
        n_cmp++; if (retry_count !== 2'd0) begin n_err++; $display("FAIL race_retry_clear got=%0d exp=0", retry_count); end
        tick();
        tick();
        force_to = 1'b1;
        op_done  = 1'b1;
        tick();
        force_to = 1'b0;
        op_done  = 1'b0;
        n_cmp++; if (done_ok !== 1'b1 || busy !== 1'b0 || timer_reset !== 1'b1) begin
            n_err++; $display("FAIL race_done got=%b/%b/%b exp=1/0/1", done_ok, busy, timer_reset);
        end
        tick();
        n_cmp++; if (cnt_abort - a0 !== 0) begin n_err++; $display("FAIL race_no_abort got=%0d exp=0", cnt_abort - a0); end
    endtask

    task automatic test_ignored_inputs();
        start_op();
        tick();
        op_start = 1'b1;
        err_ack  = 1'b1;
        tick();
        op_start = 1'b0;
        err_ack  = 1'b0;
        n_cmp++; if (busy !== 1'b1 || timer_reset !== 1'b0 || op_issue !== 1'b0) begin
            n_err++; $display("FAIL ign_start_in_wait got=%b/%b/%b exp=1/0/0", busy, timer_reset, op_issue);
        end
        force_to = 1'b1;
        tick();
        force_to = 1'b0;
        n_cmp++; if (op_abort !== 1'b1) begin n_err++; $display("FAIL ign_abort got=%b exp=1", op_abort); end
        tick();
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        n_cmp++; if (busy !== 1'b1 || done_ok !== 1'b0 || op_issue !== 1'b0 || op_abort !== 1'b0) begin
            n_err++; $display("FAIL ign_done_in_backoff got=%b/%b/%b/%b exp=1/0/0/0", busy, done_ok, op_issue, op_abort);
        end
        tick();
        tick();
        n_cmp++; if (op_issue !== 1'b0 || timer_reset !== 1'b1) begin
            n_err++; $display("FAIL ign_backoff_len got=%b/%b exp=0/1", op_issue, timer_reset);
        end
        tick();
        n_cmp++; if (op_issue !== 1'b1) begin n_err++; $display("FAIL ign_reissue got=%b exp=1", op_issue); end
        tick();
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        n_cmp++; if (done_ok !== 1'b1 || retry_count !== 2'd1) begin
            n_err++; $display("FAIL ign_final got=%b/%0d exp=1/1", done_ok, retry_count);
        end
        tick();
    endtask

    task automatic test_reset_midop();
        int a0, o0, e0;
        a0 = cnt_abort; o0 = cnt_ok; e0 = cnt_err;
        start_op();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0 || timer_reset !== 1'b1 || retry_count !== 2'd0 || done_ok !== 1'b0 || done_err !== 1'b0) begin
            n_err++; $display("FAIL rst_wait got=%b/%b/%0d/%b/%b exp=0/1/0/0/0", busy, timer_reset, retry_count, done_ok, done_err);
        end
        tick();
        start_op();
        tick();
        force_to = 1'b1;
        tick();
        force_to = 1'b0;
        tick();
        n_cmp++; if (retry_count !== 2'd1 || busy !== 1'b1) begin
            n_err++; $display("FAIL rst_pre_backoff got=%0d/%b exp=1/1", retry_count, busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0 || timer_reset !== 1'b1 || retry_count !== 2'd0 || op_abort !== 1'b0) begin
            n_err++; $display("FAIL rst_backoff got=%b/%b/%0d/%b exp=0/1/0/0", busy, timer_reset, retry_count, op_abort);
        end
        for (int k = 0; k < 6; k++) tick();
        n_cmp++; if (busy !== 1'b0 || op_issue !== 1'b0) begin
            n_err++; $display("FAIL rst_stays_idle got=%b/%b exp=0/0", busy, op_issue);
        end
        n_cmp++; if (cnt_abort - a0 !== 1 || cnt_ok - o0 !== 0 || cnt_err - e0 !== 0) begin
            n_err++; $display("FAIL rst_pulses got=%0d/%0d/%0d exp=1/0/0", cnt_abort - a0, cnt_ok - o0, cnt_err - e0);
        end
    endtask

    initial begin
        test_reset();
        test_success();
        test_exhaust();
        test_retry_success();
        test_done_vs_timeout();
        test_ignored_inputs();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
